// File: rtl/wind_pattern_decoder_if.sv
// Pattern-in / status-out bundle between a wind pattern source and its decoder.
// The source side drives sample_en/pattern; the decoder side drives the status.
interface wind_pattern_decoder_if #(
    parameter int RUN_W = 8
);
    logic             sample_en;
    logic [2:0]       pattern;
    logic [1:0]       mode;
    logic             locked;
    logic             err;
    logic [RUN_W-1:0] run_len;

    modport master (
        output sample_en, pattern,
        input  mode, locked, err, run_len
    );

    modport slave (
        input  sample_en, pattern,
        output mode, locked, err, run_len
    );
endinterface

// File: rtl/wind_pattern_decoder.sv
// Classifies the 3-LED wind pattern stream as calm / sweep A / sweep B and locks
// after LOCK_COUNT consistent prev->cur transitions.
//
// state  | meaning
// IDLE   | no valid previous pattern yet
// TRACK  | have prev, counting consecutive same-class transitions toward lock
// LOCKED | mode valid, run_len keeps counting (saturating) while the class holds
module wind_pattern_decoder #(
    parameter int LOCK_COUNT = 3,
    parameter int RUN_W      = 8
) (
    input  logic clk,
    input  logic reset,
    wind_pattern_decoder_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_TRACK,
        S_LOCKED
    } state_t;

    // Class codes double as mode codes, so mode <= class needs no mapping.
    localparam logic [1:0] CLS_NONE = 2'b00;
    localparam logic [1:0] CLS_CALM = 2'b01;
    localparam logic [1:0] CLS_A    = 2'b10;
    localparam logic [1:0] CLS_B    = 2'b11;

    localparam logic [RUN_W-1:0] RUN_ZERO = '0;
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
    localparam logic [RUN_W-1:0] RUN_MAX  = '1;
    localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_COUNT);

    state_t           state;
    logic [2:0]       prev;
    logic [1:0]       cand;
    logic [1:0]       mode;
    logic             locked;
    logic             err;
    logic [RUN_W-1:0] run_len;

    logic             legal;
    logic             hold;
    logic [1:0]       cls;
    logic [RUN_W-1:0] run_next;
    logic [RUN_W-1:0] run_inc;

    always_comb begin
        legal = (bus.pattern == 3'b101) || (bus.pattern == 3'b010) ||
                (bus.pattern == 3'b100) || (bus.pattern == 3'b001);
        hold  = (bus.pattern == prev);
        cls   = CLS_NONE;
        case ({prev, bus.pattern})
            6'b101_010, 6'b010_101:             cls = CLS_CALM;
            6'b100_010, 6'b010_001, 6'b001_100: cls = CLS_A;
            6'b001_010, 6'b010_100, 6'b100_001: cls = CLS_B;
            default:                            cls = CLS_NONE;
        endcase
        // In TRACK run_len stays below LOCK_COUNT, so this increment cannot wrap.
        run_next = (cls == cand) ? run_len + RUN_ONE : RUN_ONE;
        run_inc  = (run_len == RUN_MAX) ? run_len : run_len + RUN_ONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            prev    <= 3'b000;
            cand    <= CLS_NONE;
            mode    <= CLS_NONE;
            locked  <= 1'b0;
            err     <= 1'b0;
            run_len <= RUN_ZERO;
        end else begin
            err <= 1'b0;
            if (bus.sample_en) begin
                case (state)
                    S_IDLE: begin
                        if (legal) begin
                            prev    <= bus.pattern;
                            cand    <= CLS_NONE;
                            run_len <= RUN_ZERO;
                            state   <= S_TRACK;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    default: begin
                        if (!legal) begin
                            err     <= 1'b1;
                            locked  <= 1'b0;
                            mode    <= CLS_NONE;
                            cand    <= CLS_NONE;
                            run_len <= RUN_ZERO;
                            prev    <= 3'b000;
                            state   <= S_IDLE;
                        end else if (!hold) begin
                            prev <= bus.pattern;
                            if (cls == CLS_NONE) begin
                                err     <= 1'b1;
                                locked  <= 1'b0;
                                mode    <= CLS_NONE;
                                cand    <= CLS_NONE;
                                run_len <= RUN_ZERO;
                                state   <= S_TRACK;
                            end else if (state == S_LOCKED) begin
                                if (cls == mode) begin
                                    run_len <= run_inc;
                                end else if (LOCK_COUNT == 1) begin
                                    // One transition is already a full lock run.
                                    mode    <= cls;
                                    cand    <= cls;
                                    run_len <= RUN_ONE;
                                end else begin
                                    locked  <= 1'b0;
                                    mode    <= CLS_NONE;
                                    cand    <= cls;
                                    run_len <= RUN_ONE;
                                    state   <= S_TRACK;
                                end
                            end else begin
                                cand    <= cls;
                                run_len <= run_next;
                                if (run_next == RUN_LOCK) begin
                                    mode   <= cls;
                                    locked <= 1'b1;
                                    state  <= S_LOCKED;
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign bus.mode    = mode;
    assign bus.locked  = locked;
    assign bus.err     = err;
    assign bus.run_len = run_len;
endmodule

// File: tb/tb_wind_pattern_decoder.sv
// Self-checking bench for wind_pattern_decoder: directed scenarios plus a
// randomized run against a rule-level reference model.
module tb_wind_pattern_decoder;
    localparam int LC   = 3;
    localparam int RW   = 8;
    localparam int RW_S = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wind_pattern_decoder_if #(.RUN_W(RW))   bus ();
    wind_pattern_decoder_if #(.RUN_W(RW_S)) bus_s ();

    wind_pattern_decoder #(.LOCK_COUNT(LC), .RUN_W(RW)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    wind_pattern_decoder #(.LOCK_COUNT(LC), .RUN_W(RW_S)) dut_s (
        .clk(clk), .reset(reset), .bus(bus_s)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit         m_have;
    logic [2:0] m_prev;
    int         m_cand, m_run, m_mode;
    bit         m_locked, m_err;

    function automatic bit is_legal(logic [2:0] p);
        return (p == 3'b101) || (p == 3'b010) || (p == 3'b100) || (p == 3'b001);
    endfunction

    // A: single lit LED moves right (wrapping); B: moves left; calm: complement swap.
    function automatic int trans_class(logic [2:0] p, logic [2:0] c);
        if ($countones(p) == 1 && $countones(c) == 1) begin
            if (c == {p[0], p[2:1]}) return 2;
            if (c == {p[1:0], p[2]}) return 3;
        end
        if (is_legal(p) && is_legal(c) && ((p ^ c) == 3'b111)) return 1;
        return 0;
    endfunction

    task automatic m_clear();
        m_cand = 0; m_run = 0; m_mode = 0; m_locked = 0;
    endtask

    task automatic m_reset();
        m_have = 0; m_prev = 3'b000; m_err = 0;
        m_clear();
    endtask

    task automatic model_step(input logic en, input logic [2:0] pat);
        int c;
        int rmax;
        rmax  = (1 << RW) - 1;
        m_err = 0;
        if (!en) return;
        if (!m_have) begin
            if (is_legal(pat)) begin
                m_have = 1; m_prev = pat; m_cand = 0; m_run = 0;
            end else begin
                m_err = 1;
            end
            return;
        end
        if (!is_legal(pat)) begin
            m_err = 1; m_have = 0; m_clear();
            return;
        end
        if (pat == m_prev) return;
        c = trans_class(m_prev, pat);
        m_prev = pat;
        if (c == 0) begin
            m_err = 1; m_clear();
            return;
        end
        if (m_locked) begin
            if (c == m_mode) begin
                m_run = (m_run + 1 > rmax) ? rmax : m_run + 1;
            end else begin
                m_locked = 0; m_mode = 0; m_cand = c; m_run = 1;
                if (LC == 1) begin m_locked = 1; m_mode = c; end
            end
        end else begin
            m_run  = (c == m_cand) ? m_run + 1 : 1;
            m_cand = c;
            if (m_run == LC) begin m_locked = 1; m_mode = c; end
        end
    endtask

    function automatic logic [11:0] obs();
        return {bus.mode, bus.locked, bus.err, bus.run_len};
    endfunction

    function automatic logic [11:0] w(int md, int lk, int er, int rn);
        logic [1:0] md_b;
        logic [7:0] rn_b;
        md_b = md[1:0];
        rn_b = rn[7:0];
        return {md_b, lk[0], er[0], rn_b};
    endfunction

    function automatic logic [6:0] obs_s();
        return {bus_s.mode, bus_s.locked, bus_s.err, bus_s.run_len};
    endfunction

    task automatic step(input logic en, input logic [2:0] pat);
        bus.sample_en = en;
        bus.pattern   = pat;
        @(posedge clk);
        #1;
        model_step(en, pat);
    endtask

    task automatic step_s(input logic en, input logic [2:0] pat);
        bus_s.sample_en = en;
        bus_s.pattern   = pat;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.sample_en   = 1'b0;
        bus_s.sample_en = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        m_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs() !== w(0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_main actual=%h expected=%h", obs(), w(0, 0, 0, 0));
        end
        checks++;
        if (obs_s() !== 7'd0) begin
            errors++;
            $display("FAIL reset_small actual=%h expected=%h", obs_s(), 7'd0);
        end
    endtask

    task automatic test_calm_lock();
        logic [2:0]  pats [4];
        logic [11:0] exps [4];
        pats = '{3'b101, 3'b010, 3'b101, 3'b010};
        exps = '{w(0,0,0,0), w(0,0,0,1), w(0,0,0,2), w(1,1,0,3)};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, pats[i]);
            checks++;
            if (obs() !== exps[i]) begin
                errors++;
                $display("FAIL calm_lock step%0d actual=%h expected=%h", i, obs(), exps[i]);
            end
        end
    endtask

    task automatic test_sweep_a();
        logic [2:0]  pats [5];
        logic [11:0] exps [5];
        pats = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b010};
        exps = '{w(0,0,0,0), w(0,0,0,1), w(0,0,0,2), w(2,1,0,3), w(2,1,0,4)};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, pats[i]);
            checks++;
            if (obs() !== exps[i]) begin
                errors++;
                $display("FAIL sweep_a step%0d actual=%h expected=%h", i, obs(), exps[i]);
            end
        end
    endtask

    task automatic test_b_error_relock();
        logic [2:0]  pats [8];
        logic [11:0] exps [8];
        pats = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b101, 3'b010, 3'b101, 3'b010};
        exps = '{w(0,0,0,0), w(0,0,0,1), w(0,0,0,2), w(3,1,0,3),
                 w(0,0,1,0), w(0,0,0,1), w(0,0,0,2), w(1,1,0,3)};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, pats[i]);
            checks++;
            if (obs() !== exps[i]) begin
                errors++;
                $display("FAIL b_error_relock step%0d actual=%h expected=%h", i, obs(), exps[i]);
            end
        end
    endtask

    task automatic test_a_to_b_switch();
        logic [2:0]  pats [8];
        logic [11:0] exps [8];
        pats = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b010, 3'b100, 3'b001, 3'b010};
        exps = '{w(0,0,0,0), w(0,0,0,1), w(0,0,0,2), w(2,1,0,3),
                 w(2,1,0,4), w(0,0,0,1), w(0,0,0,2), w(3,1,0,3)};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, pats[i]);
            checks++;
            if (obs() !== exps[i]) begin
                errors++;
                $display("FAIL a_to_b step%0d actual=%h expected=%h", i, obs(), exps[i]);
            end
        end
    endtask

    task automatic test_illegal_idle();
        logic        ens  [5];
        logic [2:0]  pats [5];
        logic [11:0] exps [5];
        ens  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        pats = '{3'b111, 3'b000, 3'b010, 3'b101, 3'b010};
        exps = '{w(0,0,1,0), w(0,0,1,0), w(0,0,0,0), w(0,0,0,0), w(0,0,0,1)};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(ens[i], pats[i]);
            checks++;
            if (obs() !== exps[i]) begin
                errors++;
                $display("FAIL illegal_idle step%0d actual=%h expected=%h", i, obs(), exps[i]);
            end
        end
    endtask

    task automatic test_hold();
        do_reset();
        step(1'b1, 3'b101);
        step(1'b1, 3'b010);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 3'b010);
            checks++;
            if (obs() !== w(0, 0, 0, 1)) begin
                errors++;
                $display("FAIL hold step%0d actual=%h expected=%h", i, obs(), w(0, 0, 0, 1));
            end
        end
    endtask

    task automatic test_sample_en_low();
        do_reset();
        step(1'b1, 3'b101);
        step(1'b1, 3'b010);
        step(1'b1, 3'b101);
        step(1'b1, 3'b010);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 3'($urandom_range(0, 7)));
            checks++;
            if (obs() !== w(1, 1, 0, 3)) begin
                errors++;
                $display("FAIL en_low step%0d actual=%h expected=%h", i, obs(), w(1, 1, 0, 3));
            end
        end
    endtask

    task automatic test_async_reset();
        logic [2:0] pats [6];
        pats = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b010, 3'b001};
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, pats[i]);
        checks++;
        if (obs() !== w(2, 1, 0, 5)) begin
            errors++;
            $display("FAIL pre_reset actual=%h expected=%h", obs(), w(2, 1, 0, 5));
        end
        bus.sample_en = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (obs() !== w(0, 0, 0, 0)) begin
            errors++;
            $display("FAIL async_reset actual=%h expected=%h", obs(), w(0, 0, 0, 0));
        end
        #1;
        reset = 1'b0;
        m_reset();
        step(1'b1, 3'b010);
        step(1'b1, 3'b100);
        checks++;
        if (obs() !== w(0, 0, 0, 1)) begin
            errors++;
            $display("FAIL after_reset actual=%h expected=%h", obs(), w(0, 0, 0, 1));
        end
    endtask

    task automatic test_saturation();
        logic [2:0] a_seq [3];
        logic [6:0] exp7;
        int         r;
        a_seq = '{3'b100, 3'b010, 3'b001};
        do_reset();
        step_s(1'b1, 3'b100);
        checks++;
        if (obs_s() !== 7'd0) begin
            errors++;
            $display("FAIL sat_start actual=%h expected=%h", obs_s(), 7'd0);
        end
        for (int k = 1; k <= 10; k++) begin
            step_s(1'b1, a_seq[k % 3]);
            r = (k > 7) ? 7 : k;
            exp7 = (k < LC) ? {2'b00, 1'b0, 1'b0, 3'(r)} : {2'b10, 1'b1, 1'b0, 3'(r)};
            checks++;
            if (obs_s() !== exp7) begin
                errors++;
                $display("FAIL saturation k%0d actual=%h expected=%h", k, obs_s(), exp7);
            end
        end
        bus_s.sample_en = 1'b0;
    endtask

    task automatic test_random();
        logic [2:0] seqs [3][3];
        int         dir, pos, r;
        logic       en;
        logic [2:0] pat;
        seqs = '{'{3'b101, 3'b010, 3'b101}, '{3'b100, 3'b010, 3'b001}, '{3'b001, 3'b010, 3'b100}};
        do_reset();
        dir = 0; pos = 0; pat = 3'b101;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) < 5) dir = $urandom_range(0, 2);
            en = ($urandom_range(0, 3) != 0);
            r  = $urandom_range(0, 99);
            if (r < 75) begin
                pos++;
                pat = (dir == 0) ? seqs[0][pos % 2] : seqs[dir][pos % 3];
            end else if (r < 85) begin
                case ($urandom_range(0, 3))
                    0: pat = 3'b101;
                    1: pat = 3'b010;
                    2: pat = 3'b100;
                    default: pat = 3'b001;
                endcase
            end else if (r >= 92) begin
                pat = 3'($urandom_range(0, 7));
            end
            step(en, pat);
            checks++;
            if (obs() !== w(m_mode, int'(m_locked), int'(m_err), m_run)) begin
                errors++;
                $display("FAIL random cyc%0d en=%0b pat=%b actual=%h expected=%h",
                         i, en, pat, obs(), w(m_mode, int'(m_locked), int'(m_err), m_run));
            end
        end
    endtask

    initial begin
        reset           = 1'b1;
        bus.sample_en   = 1'b0;
        bus.pattern     = 3'b000;
        bus_s.sample_en = 1'b0;
        bus_s.pattern   = 3'b000;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_calm_lock();
        test_sweep_a();
        test_b_error_relock();
        test_a_to_b_switch();
        test_illegal_idle();
        test_hold();
        test_sample_en_low();
        test_async_reset();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wind_pattern_decoder.md
Name: wind_pattern_decoder

Overview:
- Receive-side counterpart of the 3-LED wind pattern generator; watches the 3-bit pattern the generator drives (LEDR[2:0]) one step at a time.
- Classifies the pattern stream as calm, A-direction sweep or B-direction sweep, and locks once enough consistent steps are seen.
- Reports mode, lock status, a one-cycle error pulse and a saturating run length, so a board top level can show on LEDs/HEX which mode the generator is in.

Parameters:
- LOCK_COUNT, 3: consecutive same-class transitions required to assert locked (range 1 to 2^RUN_W-1).
- RUN_W, 8: width of run_len.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- sample_en  input  1  one pattern step is present this cycle; high for consecutive cycles means one step per cycle.
- pattern  input  3  observed LED pattern, bit 2 = leftmost LED.
- mode  output  2  00 unknown, 01 calm, 10 sweep A, 11 sweep B.
- locked  output  1  high while mode is valid.
- err  output  1  one-cycle pulse on an illegal pattern or illegal transition.
- run_len  output  RUN_W  count of consecutive same-class transitions; saturates at all-ones.

Behaviour:
- Reset values: mode=00, locked=0, err=0, run_len=0, state=IDLE, prev=000, cand=none.
- All outputs registered. An effect appears the cycle after the sample_en edge (1-cycle latency). With sample_en low, all outputs hold, and err is 0.
- Legal patterns: 101, 010, 100, 001. Illegal patterns: 000, 011, 110, 111.
- Transition classes (prev -> cur):
  - calm: 101->010, 010->101.
  - A: 100->010, 010->001, 001->100.
  - B: 001->010, 010->100, 100->001.
  - hold: prev==cur. Treated as a generator stall: no state, run or output change, no err.
  - Every other transition is invalid.
- State IDLE (no valid prev):
  - Legal pattern: prev<=pattern, go TRACK, cand=none, run_len=0.
  - Illegal pattern: err pulse, stay IDLE.
- State TRACK:
  - Valid class c equal to cand: run_len+1.
  - Valid class c differing from cand: cand<=c, run_len<=1.
  - In both cases prev<=pattern.
  - When run_len becomes LOCK_COUNT: go LOCKED, mode<=cand, locked<=1, in the same update.
- State LOCKED:
  - Class equal to mode: run_len+1, saturating; prev<=pattern.
  - Different valid class (switches changed): locked<=0, mode<=00, cand<=new class, run_len<=1, go TRACK, no err.
- Invalid transition or illegal pattern in TRACK or LOCKED:
  - err pulse; locked<=0, mode<=00, cand=none, run_len<=0.
  - If pattern is legal: prev<=pattern, go or stay TRACK.
  - If pattern is illegal: go IDLE.
- LOCK_COUNT=1 locks on the first valid transition.
- Ambiguity at 010 is resolved only by the prev/cur pair. A single sample is never classified.
- Reset asserted mid-operation clears everything asynchronously, regardless of clk or sample_en. The first sample after reset release is treated as coming from IDLE.
- err is never high for two consecutive cycles unless two consecutive samples are both faulty.

Test Plan:
- Reset, then sample 101,010,101,010 on consecutive cycles (LOCK_COUNT=3) -> after the 4th sample: mode=01, locked=1, run_len=3, err never high.
- Sample 100,010,001,100,010 -> locked with mode=10 after the 4th sample; run_len=4 after the 5th.
- Locked in B (001,010,100,001), then sample 101 -> err=1 for one cycle; locked=0, mode=00, run_len=0; next samples 010,101,010 -> relock to mode=01.
- Locked in A, then samples 010,100 (B transition), 001,010 -> no err; locked drops on the first B transition with run_len=1; mode=11 after the 3rd B transition.
- Illegal 111 from IDLE -> err pulse, state stays IDLE. Repeated 010,010,010 with sample_en -> no change. sample_en=0 with a changing pattern -> outputs hold.
- Assert reset while locked with run_len=5 -> mode=00, locked=0, run_len=0 immediately, before the next clk edge. With RUN_W=3, drive 10 A transitions -> run_len saturates at 7.
